// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: board-level run control and performance monitor.
// Produces a single-clock enable for the core in free/slow/step/hold
// modes, counts enabled cycles and retired instructions, latches the
// end-of-program flag and drives a selectable value onto 7-seg digits.
module cpu_run_monitor #(
    parameter int DIV_MAX    = 50000000,
    parameter int DEB_CYCLES = 500000,
    parameter int CNT_WIDTH  = 32,
    parameter int NUM_DIGITS = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              mode,
    input  logic                    step_key,
    input  logic                    endcontrol,
    input  logic                    instr_valid,
    input  logic [31:0]             pc,
    input  logic [1:0]              sel,
    output logic                    cpu_en,
    output logic                    halted,
    output logic [CNT_WIDTH-1:0]    cycle_count,
    output logic [CNT_WIDTH-1:0]    instret_count,
    output logic [7*NUM_DIGITS-1:0] hex
);

    typedef enum logic [1:0] {
        MODE_FREE = 2'b00,
        MODE_SLOW = 2'b01,
        MODE_STEP = 2'b10,
        MODE_HOLD = 2'b11
    } mode_t;

    localparam int DIV_W = (DIV_MAX > 2) ? $clog2(DIV_MAX) : 1;
    localparam int DEB_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam int VAL_W = 4 * NUM_DIGITS;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_MAX - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    mode_t                    w_mode;
    mode_t                    r_mode_prev;
    logic [DIV_W-1:0]         r_div;
    logic                     w_tick;
    logic                     r_sync1, r_sync2;
    logic                     r_deb_level, r_deb_prev;
    logic [DEB_W-1:0]         r_deb_cnt;
    logic                     w_press;
    logic                     w_en_mode, w_en_next;
    logic                     r_cpu_en, r_halted;
    logic [CNT_WIDTH-1:0]     r_cycle, r_instret, w_diff;
    logic [VAL_W-1:0]         w_value;
    logic [7*NUM_DIGITS-1:0]  w_hex_next, r_hex;

    assign w_mode = mode_t'(mode);

    // Gate the wrap point: a tick is only produced once the mode has been
    // stable for at least one cycle, so a mode change never leaks a tick.
    assign w_tick = (w_mode == MODE_SLOW) && (w_mode == r_mode_prev) && (r_div == DIV_LAST);

    // Slow-run divider, restarted whenever the mode changes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mode_prev <= MODE_FREE;
            r_div       <= '0;
        end else begin
            r_mode_prev <= w_mode;
            if (w_mode != r_mode_prev) begin
                r_div <= '0;
            end else if (w_mode == MODE_SLOW) begin
                r_div <= w_tick ? '0 : r_div + 1'b1;
            end
        end
    end

    // Step key: two-flop synchronizer followed by a stability-count debouncer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_deb_level <= 1'b1;
            r_deb_prev  <= 1'b1;
            r_deb_cnt   <= '0;
        end else begin
            r_sync1    <= step_key;
            r_sync2    <= r_sync1;
            r_deb_prev <= r_deb_level;
            if (r_sync2 != r_deb_level) begin
                if (r_deb_cnt == DEB_LAST) begin
                    r_deb_level <= r_sync2;
                    r_deb_cnt   <= '0;
                end else begin
                    r_deb_cnt <= r_deb_cnt + 1'b1;
                end
            end else begin
                r_deb_cnt <= '0;
            end
        end
    end

    // Press is the falling edge of the debounced (active-low) key level.
    assign w_press = r_deb_prev & ~r_deb_level;

    // Next clock-enable value from the run mode, blocked by end-of-program.
    always_comb begin
        w_en_mode = 1'b0;
        case (w_mode)
            MODE_FREE: w_en_mode = 1'b1;
            MODE_SLOW: w_en_mode = w_tick;
            MODE_STEP: w_en_mode = w_press;
            MODE_HOLD: w_en_mode = 1'b0;
            default:   w_en_mode = 1'b0;
        endcase
        w_en_next = w_en_mode & ~r_halted & ~endcontrol;
    end

    // Registered enable, sticky halt and saturating performance counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cpu_en  <= 1'b0;
            r_halted  <= 1'b0;
            r_cycle   <= '0;
            r_instret <= '0;
        end else begin
            r_cpu_en <= w_en_next;
            r_halted <= r_halted | endcontrol;
            if (r_cpu_en && !r_halted) begin
                if (r_cycle != '1) begin
                    r_cycle <= r_cycle + 1'b1;
                end
                if (instr_valid && (r_instret != '1)) begin
                    r_instret <= r_instret + 1'b1;
                end
            end
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        case (nib)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    assign w_diff = r_cycle - r_instret;

    // Display source select, resized to the digit field, then per-digit encode.
    always_comb begin
        w_value = '0;
        case (sel)
            2'd0:    w_value = VAL_W'(r_cycle);
            2'd1:    w_value = VAL_W'(r_instret);
            2'd2:    w_value = VAL_W'(pc);
            default: w_value = VAL_W'(w_diff);
        endcase
        w_hex_next = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            w_hex_next[7*k +: 7] = seg7(w_value[4*k +: 4]);
        end
    end

    // Registered segment outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hex <= {NUM_DIGITS{7'h40}};
        end else begin
            r_hex <= w_hex_next;
        end
    end

    assign cpu_en        = r_cpu_en;
    assign halted        = r_halted;
    assign cycle_count   = r_cycle;
    assign instret_count = r_instret;
    assign hex           = r_hex;

endmodule
